// File: rtl/seg7_page_scheduler.sv
// Round-robin owner of the 8-digit display value with a preempting override.
// Drives seg7_display.number; one owner per dwell window.
module seg7_page_scheduler #(
  parameter int          N_SRC        = 4,
  parameter int          DWELL_CYCLES = 100_000_000,
  parameter logic [31:0] IDLE_VALUE   = 32'h0000_0000
) (
  input  logic                  CLK100MHZ,
  input  logic                  CPU_RESET,
  input  logic [N_SRC-1:0]      req,
  input  logic [32*N_SRC-1:0]   src_value,
  input  logic                  pri_valid,
  input  logic [31:0]           pri_value,
  output logic [31:0]           number,
  output logic [N_SRC-1:0]      grant,
  output logic                  ovr_active,
  output logic                  page_start
);

  localparam int IW = $clog2(N_SRC);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_SHOW = 2'd2;
  localparam logic [1:0] S_OVR  = 2'd3;

  localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
  localparam logic [N_SRC-1:0] ONE = {{(N_SRC-1){1'b0}}, 1'b1};

  logic [1:0]    state;
  logic [IW-1:0] owner;
  logic [31:0]   dwell;
  logic          start_incl;

  logic [IW-1:0] win;
  logic          win_ok;
  logic [31:0]   owner_val;
  logic [31:0]   win_val;

  // Circular search: start at owner (resume) or owner+1 (rotate).
  always_comb begin
    int base;
    int j;
    logic [IW-1:0] idx;
    win    = owner;
    win_ok = 1'b0;
    j      = 0;
    idx    = '0;
    base   = int'(owner) + (start_incl ? 0 : 1);
    if (base >= N_SRC) base = base - N_SRC;
    for (int i = 0; i < N_SRC; i++) begin
      j = base + i;
      if (j >= N_SRC) j = j - N_SRC;
      idx = IW'(j);
      if (!win_ok && req[idx]) begin
        win    = idx;
        win_ok = 1'b1;
      end
    end
  end

  assign owner_val = src_value[int'(owner)*32 +: 32];
  assign win_val   = src_value[int'(win)*32 +: 32];

  always_ff @(posedge CLK100MHZ) begin
    if (CPU_RESET) begin
      state      <= S_IDLE;
      owner      <= IW'(N_SRC - 1);
      dwell      <= '0;
      start_incl <= 1'b0;
      number     <= IDLE_VALUE;
      grant      <= '0;
      ovr_active <= 1'b0;
      page_start <= 1'b0;
    end else begin
      page_start <= 1'b0;
      if (pri_valid) begin
        state      <= S_OVR;
        number     <= pri_value;
        grant      <= '0;
        ovr_active <= 1'b1;
        dwell      <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            number <= IDLE_VALUE;
            grant  <= '0;
            if (|req) begin
              state      <= S_ARB;
              start_incl <= 1'b0;
            end
          end
          S_ARB: begin
            if (win_ok) begin
              grant      <= ONE << win;
              owner      <= win;
              number     <= win_val;
              page_start <= 1'b1;
              dwell      <= '0;
              state      <= S_SHOW;
            end else begin
              number <= IDLE_VALUE;
              grant  <= '0;
              state  <= S_IDLE;
            end
          end
          S_SHOW: begin
            number <= owner_val;
            // Leaving clears dwell so it never passes DWELL_LAST.
            if (!req[owner] || dwell == DWELL_LAST) begin
              state      <= S_ARB;
              start_incl <= 1'b0;
              dwell      <= '0;
            end else begin
              dwell <= dwell + 32'd1;
            end
          end
          S_OVR: begin
            number     <= pri_value;
            grant      <= '0;
            ovr_active <= 1'b0;
            start_incl <= 1'b1;
            state      <= S_ARB;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
